uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
- Downstream consumer of the core's UART outputs (tx_start, tx_data); drives the board's serial TX pin.
- Detects rising edges of the core's level-held tx_start, buffers bytes in a small FIFO, and serialises them as 8N1 frames, LSB first.
- Decouples the core's 5-stage instruction loop from the much slower baud rate. Bytes are dropped only on overflow, which is flagged.

Parameters:
- CLKS_PER_BIT, 208, clock cycles per UART bit (24 MHz / 115200); legal range ≥ 2.
- DEPTH, 8, FIFO entries; power of 2, ≥ 2.

Ports:
- clock  input  1  system clock; all state updates on posedge.
- reset_n  input  1  asynchronous, active-low reset.
- tx_start  input  1  byte strobe from the core, level-held; only its rising edge is used.
- tx_data  input  8  byte to send; sampled in the cycle tx_start rises.
- tx  output  1  serial line; idles high.
- busy  output  1  high while a frame is in flight or the FIFO is non-empty.
- full  output  1  FIFO holds DEPTH entries.
- overflow  output  1  one-cycle pulse when a push is dropped.

Behaviour:
- Reset (async assert, sync release):
  - tx=1, busy=0, full=0, overflow=0.
  - FIFO empty, FSM=IDLE, bit and baud counters 0.
  - Edge-detect register start_q=0.
  - A mid-frame reset aborts the frame; tx returns high immediately, without waiting for a clock edge.
- Push:
  - Condition: tx_start==1 && start_q==0.
  - start_q<=tx_start every cycle.
  - If tx_start is already high at reset release, one push occurs on the first clock edge.
- FIFO:
  - Read/write pointers log2(DEPTH)+1 bits wide; wrap modulo 2*DEPTH.
  - Empty when the pointers are equal; full when the low bits are equal and the MSBs differ.
  - Push when full with no pop in the same cycle: byte dropped, overflow=1 for one cycle, pointers unchanged.
  - Push and pop in the same cycle: both succeed, including when full. Count is unchanged; full stays as it was, overflow=0.
  - Pop when empty never occurs; the FSM only pops when non-empty.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE, FIFO non-empty: pop head into shift register, baud counter=0, go to START. tx goes low on the edge after the push edge, i.e. 1-cycle latency from push to start bit.
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA with bit index 0.
  - DATA: tx=shift[0] for CLKS_PER_BIT cycles per bit. Shift right after each bit. After bit 7 go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. At the end, if the FIFO is non-empty, pop and go directly to START (no idle gap). Otherwise go to IDLE.
  - Baud counter counts 0..CLKS_PER_BIT-1 and wraps; a state or bit advances when it reaches CLKS_PER_BIT-1.
- Frame timing: exactly 10*CLKS_PER_BIT cycles. Back-to-back frames are contiguous.
- Output timing:
  - tx is registered; no combinational path from inputs.
  - busy = (state!=IDLE) || !empty, registered-equivalent, with no glitch between back-to-back frames.
- The shift register and tx_data are 8 bits; there are no parity or extra stop bits.

Test Plan:
- Bench parameters for all scenarios: CLKS_PER_BIT=4, DEPTH=4.
- Single byte: reset, then raise tx_start with tx_data=0xA5 and hold high → tx falls 1 cycle later. Bit pattern 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles. busy=1 for 40 cycles, then tx=1, busy=0.
- Level hold: hold tx_start=1 for 200 cycles → exactly one frame sent. Toggle 0→1 again → a second frame follows.
- Back-to-back: push 0x01, 0x02, 0x03 on three rising edges 2 cycles apart → three contiguous frames (120 cycles), with no high gap between the stop bit and the next start bit.
- Overflow: while frame 0x00 is in flight, push 5 bytes 0x10..0x14 → full=1 after 4 pushes. 5th push gives overflow pulse of 1 cycle. Output order is 0x00, 0x10..0x13; 0x14 is never sent.
- Full with simultaneous pop: with the FIFO full, time a push to the STOP-end pop edge → push accepted, no overflow pulse, full stays 1, all bytes transmitted in order.
- Reset mid-frame: assert reset_n=0 during DATA bit 3 of 0x5A, asynchronously to clock → tx=1 and busy=0 without a clock edge. After release with tx_start=0, the line stays idle.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// Byte-oriented UART transmitter: rising-edge push into a small FIFO, then 8N1
// serialisation LSB first, with back-to-back frames sent without an idle gap.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 208,
  parameter int DEPTH        = 8
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx,
  output logic       busy,
  output logic       full,
  output logic       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] BAUD_ONE  = CW'(1);
  localparam logic [AW:0]   PTR_ONE   = (AW+1)'(1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] baud_cnt, baud_nx;
  logic [2:0]    bit_idx, bit_nx;
  logic [7:0]    shift, shift_nx;
  logic          tx_q, tx_nx;
  logic          start_q;
  logic [7:0]    mem [DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          empty, push, pop, push_ok, baud_end;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push    = tx_start && !start_q;
  assign push_ok = push && (!full || pop);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      start_q  <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      start_q  <= tx_start;
      overflow <= push && full && !pop;
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)     rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= tx_data;
  end

  // Serialiser: tx is registered and driven from the next-state logic.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      tx_q     <= 1'b1;
    end else begin
      state    <= state_nx;
      baud_cnt <= baud_nx;
      bit_idx  <= bit_nx;
      tx_q     <= tx_nx;
    end
  end

  always_ff @(posedge clock) begin
    shift <= shift_nx;
  end

  assign baud_end = (baud_cnt == BAUD_LAST);

  always_comb begin
    state_nx = state;
    baud_nx  = baud_cnt;
    bit_nx   = bit_idx;
    shift_nx = shift;
    tx_nx    = tx_q;
    pop      = 1'b0;
    case (state)
      IDLE: begin
        tx_nx = 1'b1;
        if (!empty) begin
          pop      = 1'b1;
          shift_nx = mem[rd_ptr[AW-1:0]];
          baud_nx  = '0;
          tx_nx    = 1'b0;
          state_nx = START;
        end
      end
      START: begin
        if (baud_end) begin
          baud_nx  = '0;
          bit_nx   = '0;
          tx_nx    = shift[0];
          state_nx = DATA;
        end else begin
          baud_nx = baud_cnt + BAUD_ONE;
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_nx  = '0;
          shift_nx = {1'b0, shift[7:1]};
          if (bit_idx == 3'd7) begin
            tx_nx    = 1'b1;
            state_nx = STOP;
          end else begin
            bit_nx = bit_idx + 3'd1;
            tx_nx  = shift[1];
          end
        end else begin
          baud_nx = baud_cnt + BAUD_ONE;
        end
      end
      STOP: begin
        if (baud_end) begin
          baud_nx = '0;
          // Chain straight into the next start bit when more bytes are queued.
          if (!empty) begin
            pop      = 1'b1;
            shift_nx = mem[rd_ptr[AW-1:0]];
            tx_nx    = 1'b0;
            state_nx = START;
          end else begin
            tx_nx    = 1'b1;
            state_nx = IDLE;
          end
        end else begin
          baud_nx = baud_cnt + BAUD_ONE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign tx   = tx_q;
  assign busy = (state != IDLE) || !empty;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: queue-based line model checked every cycle, a line
// receiver decoding frames, and directed scenarios with literal expectations.
module tb_uart_tx_fifo;

  localparam int CPB   = 4;
  localparam int DEP   = 4;
  localparam int FRAME = 10 * CPB;

  logic       clock = 1'b0;
  logic       reset_n = 1'b1;
  logic       tx_start = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx, busy, full, overflow;

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DEPTH(DEP)) dut (
    .clock(clock), .reset_n(reset_n), .tx_start(tx_start), .tx_data(tx_data),
    .tx(tx), .busy(busy), .full(full), .overflow(overflow)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  bit cmp_en = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Line model: a byte queue plus the position inside the frame on the wire.
  logic [7:0] m_q[$];
  logic [7:0] m_sent[$];
  bit         m_active;
  int         m_pos;
  logic [7:0] m_cur;
  bit         m_prev;
  bit         m_ov;

  function automatic logic line_bit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx == 9) return 1'b1;
    return b[idx-1];
  endfunction

  task automatic m_clear();
    m_q.delete();
    m_active = 1'b0;
    m_pos = 0;
    m_prev = 1'b0;
    m_ov = 1'b0;
  endtask

  task automatic m_step();
    bit pop, push, was_full;
    pop = (m_q.size() > 0) && (!m_active || m_pos == FRAME - 1);
    push = tx_start && !m_prev;
    was_full = (m_q.size() == DEP);
    m_ov = push && was_full && !pop;
    if (pop) begin
      m_cur = m_q.pop_front();
      m_sent.push_back(m_cur);
      m_active = 1'b1;
      m_pos = 0;
    end else if (m_active) begin
      if (m_pos == FRAME - 1) m_active = 1'b0;
      else m_pos++;
    end
    if (push && (!was_full || pop)) m_q.push_back(tx_data);
    m_prev = tx_start;
  endtask

  initial begin
    m_clear();
    forever begin
      @(posedge clock or negedge reset_n);
      if (!reset_n) m_clear();
      else m_step();
    end
  end

  initial begin
    forever begin
      @(negedge clock);
      if (cmp_en) begin
        chk("tx", tx, m_active ? line_bit(m_cur, m_pos / CPB) : 1'b1);
        chk("busy", busy, m_active || (m_q.size() > 0));
        chk("full", full, m_q.size() == DEP);
        chk("overflow", overflow, m_ov);
      end
    end
  end

  // Line receiver: samples each bit mid-period, drops frames cut by reset.
  logic [7:0] rx_q[$];
  int         rx_start[$];
  logic [9:0] rx_frame[$];
  logic [9:0] rx_fr;
  int         rx_s;
  bit         rx_ab;

  initial begin
    forever begin
      @(negedge clock);
      if (reset_n === 1'b1 && tx === 1'b0) begin
        rx_s = cyc;
        rx_ab = 1'b0;
        rx_fr = '0;
        for (int k = 1; k < FRAME; k++) begin
          @(negedge clock);
          if (reset_n !== 1'b1) rx_ab = 1'b1;
          if (k % CPB == CPB / 2) rx_fr[k / CPB] = tx;
        end
        if (!rx_ab) begin
          rx_q.push_back(rx_fr[8:1]);
          rx_start.push_back(rx_s);
          rx_frame.push_back(rx_fr);
        end
      end
    end
  end

  task automatic pulse(input logic [7:0] d, output int pe);
    @(posedge clock);
    #2 tx_start = 1'b1;
    tx_data = d;
    @(posedge clock);
    #2 pe = cyc;
    tx_start = 1'b0;
  endtask

  task automatic wait_rx(input int n, input int budget, input string name);
    for (int i = 0; i < budget; i++) begin
      if (rx_q.size() >= n) break;
      @(negedge clock);
    end
    chk(name, rx_q.size(), n);
  endtask

  task automatic wait_idle(input int budget, input string name);
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (busy === 1'b0) break;
    end
    chk(name, busy, 1'b0);
  endtask

  task automatic wait_edge(input int e);
    for (int i = 0; i < 5000; i++) begin
      @(posedge clock);
      #1;
      if (cyc >= e) break;
    end
  endtask

  int p, p0, pe, n, base;
  logic [7:0] exp_seq [6];

  initial begin
    #1 reset_n = 1'b0;
    cmp_en = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_tx", tx, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_full", full, 1'b0);
    chk("rst_overflow", overflow, 1'b0);
    #2 reset_n = 1'b1;
    repeat (2) @(posedge clock);

    // Single byte, tx_start then held high
    @(posedge clock);
    #2 tx_start = 1'b1;
    tx_data = 8'hA5;
    @(posedge clock);
    #2 p = cyc;
    @(negedge clock);
    chk("push_cycle_tx_high", tx, 1'b1);
    chk("push_cycle_busy", busy, 1'b1);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (busy !== 1'b1) break;
      n++;
    end
    chk("busy_len", n, FRAME);
    chk("tx_idle_after_frame", tx, 1'b1);
    chk("rx_count_A5", rx_q.size(), 1);
    chk("frame_A5_bits", rx_frame[0], 10'b11_0100_1010);
    chk("start_latency", rx_start[0], p + 1);
    repeat (150) @(posedge clock);
    chk("level_hold_one_frame", rx_q.size(), 1);
    #2 tx_start = 1'b0;
    @(posedge clock);
    #2 tx_start = 1'b1;
    tx_data = 8'h3C;
    @(posedge clock);
    #2 tx_start = 1'b0;
    wait_rx(2, 100, "rx_count_3C");
    chk("byte_3C", rx_q[1], 8'h3C);
    wait_idle(200, "idle_after_3C");

    // Back-to-back
    pulse(8'h01, pe);
    pulse(8'h02, pe);
    pulse(8'h03, pe);
    wait_rx(5, 300, "rx_count_b2b");
    chk("b2b_0", rx_q[2], 8'h01);
    chk("b2b_1", rx_q[3], 8'h02);
    chk("b2b_2", rx_q[4], 8'h03);
    chk("b2b_gap_1", rx_start[3] - rx_start[2], FRAME);
    chk("b2b_gap_2", rx_start[4] - rx_start[3], FRAME);
    wait_idle(200, "idle_after_b2b");

    // Overflow, then a push landing on the stop-end pop edge while full
    base = rx_q.size();
    pulse(8'h00, p0);
    pulse(8'h10, pe);
    pulse(8'h11, pe);
    pulse(8'h12, pe);
    pulse(8'h13, pe);
    @(negedge clock);
    chk("full_after_4", full, 1'b1);
    chk("no_ovf_after_4", overflow, 1'b0);
    pulse(8'h14, pe);
    @(negedge clock);
    chk("ovf_pulse", overflow, 1'b1);
    chk("full_during_ovf", full, 1'b1);
    @(negedge clock);
    chk("ovf_one_cycle", overflow, 1'b0);
    wait_edge(p0 + FRAME);
    #1 tx_start = 1'b1;
    tx_data = 8'h77;
    @(posedge clock);
    #2 tx_start = 1'b0;
    @(negedge clock);
    chk("full_kept_simul", full, 1'b1);
    chk("no_ovf_simul", overflow, 1'b0);
    wait_rx(base + 6, 400, "rx_count_ovf");
    exp_seq = '{8'h00, 8'h10, 8'h11, 8'h12, 8'h13, 8'h77};
    for (int i = 0; i < 6; i++) begin
      chk("ovf_order", rx_q[base + i], exp_seq[i]);
      if (i > 0) chk("ovf_contig", rx_start[base + i] - rx_start[base + i - 1], FRAME);
    end
    wait_idle(200, "idle_after_ovf");

    // Randomised pushes, gaps short enough to overflow at times
    repeat (30) begin
      @(posedge clock);
      #2 tx_start = 1'b1;
      tx_data = 8'($urandom);
      repeat ($urandom_range(1, 4)) @(posedge clock);
      #2 tx_start = 1'b0;
      repeat ($urandom_range(0, 45)) @(posedge clock);
    end
    wait_idle(3000, "idle_after_random");
    repeat (2) @(negedge clock);
    chk("rx_vs_model_count", rx_q.size(), m_sent.size());
    for (int i = 0; i < rx_q.size() && i < m_sent.size(); i++)
      chk("rx_vs_model_byte", rx_q[i], m_sent[i]);

    // Reset during data bit 3 of 0x5A
    pulse(8'h5A, p);
    wait_edge(p + 1 + 17);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_tx_bit3", tx, 1'b1);
    chk("async_rst_busy_bit3", busy, 1'b0);
    chk("async_rst_full_bit3", full, 1'b0);
    repeat (5) @(posedge clock);
    #3 reset_n = 1'b1;
    n = 0;
    repeat (60) begin
      @(negedge clock);
      if (tx !== 1'b1 || busy !== 1'b0) n++;
    end
    chk("idle_after_reset", n, 0);

    // Reset during a start bit, tx_start already high at release
    pulse(8'hF0, p);
    wait_edge(p + 2);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_tx_start", tx, 1'b1);
    chk("async_rst_busy_start", busy, 1'b0);
    tx_start = 1'b1;
    tx_data = 8'hC3;
    repeat (45) @(posedge clock);
    #3 reset_n = 1'b1;
    base = rx_q.size();
    wait_rx(base + 1, 200, "rx_count_release");
    chk("release_push_byte", rx_q[base], 8'hC3);
    repeat (100) @(posedge clock);
    chk("release_single_push", rx_q.size(), base + 1);
    #2 tx_start = 1'b0;
    repeat (5) @(posedge clock);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
